// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- registered, parametrised ALU with valid/ready on both sides.
//
// Commands (opcode + two operands) are accepted in IDLE. Logic, add,
// subtract and shift results are registered on the accept edge, and the
// block moves straight to DONE. MUL iterates in EXEC for G_N_BIT cycles
// (shift-add) before it reaches DONE. DONE presents a 2*G_N_BIT-bit result
// and holds it until the consumer takes it.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid && ready are both high. A valid is never withdrawn before its
// transfer. o_ready and o_valid are decoded only from the state register,
// so there is no combinational path from any input to them.
//
// Configuration macro: ALU_MUL_EN
//   defined   : opcode 111 runs the shift-add multiplier; o_err stays 0.
//   undefined : there is no multiplier datapath. Opcode 111 completes in one
//               cycle with o_res=0, o_zero=1, o_err=1.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_valid  command valid
//   o_ready  block can accept a command (IDLE)
//   i_op     000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL,
//            110 SRL, 111 MUL
//   i_s1     operand A
//   i_s2     operand B. Shifts use only its $clog2(G_N_BIT) LSBs.
//   o_valid  result valid (DONE)
//   i_ready  consumer accepts the result
//   o_res    2*G_N_BIT result
//   o_zero   low G_N_BIT bits of o_res are zero
//   o_err    unsupported opcode
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int G_N_BIT = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [2:0]             i_op,
   input  logic [G_N_BIT-1:0]     i_s1,
   input  logic [G_N_BIT-1:0]     i_s2,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [2*G_N_BIT-1:0]   o_res,
   output logic                   o_zero,
   output logic                   o_err
);

   localparam int W  = 2 * G_N_BIT;
   localparam int SW = $clog2(G_N_BIT);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     res_q, res_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;

   logic             accept;
   logic             is_mul;
   logic             mul_last;
   logic [W-1:0]     res_calc;
   logic             err_calc;
   logic [G_N_BIT:0] sum;
   logic [G_N_BIT:0] diff;
   logic [SW-1:0]    shamt;

`ifdef ALU_MUL_EN
   localparam int CW = SW + 1;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [W-1:0]       acc_q, acc_d;
   logic [W-1:0]       mcand_q, mcand_d;
   logic [G_N_BIT-1:0] mplier_q, mplier_d;
   logic [W-1:0]       acc_next;
`endif

   assign accept = (state_q == S_IDLE) && i_valid;
   assign is_mul = (i_op == OP_MUL);

   // ---------------- state register (plus datapath registers) -------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         res_q    <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef ALU_MUL_EN
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         res_q    <= res_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
`ifdef ALU_MUL_EN
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
`endif
      end
   end

   // ---------------- next-state logic --------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
`ifdef ALU_MUL_EN
               state_d = is_mul ? S_EXEC : S_DONE;
`else
               state_d = S_DONE;
`endif
            end
         end
         S_EXEC: if (mul_last) state_d = S_DONE;
         S_DONE: if (i_ready)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- output decode -----------------------------------------
   always_comb begin
      o_ready = (state_q == S_IDLE);
      o_valid = (state_q == S_DONE);
      o_res   = res_q;
      o_zero  = zero_q;
      o_err   = err_q;
   end

   // ---------------- single-cycle result -----------------------------------
   // The N+1-bit unsigned add or subtract puts the carry or borrow in bit N.
   // For the subtract, bit N is set exactly when s1 < s2.
   always_comb begin
      sum      = {1'b0, i_s1} + {1'b0, i_s2};
      diff     = {1'b0, i_s1} - {1'b0, i_s2};
      shamt    = i_s2[SW-1:0];
      res_calc = '0;
      err_calc = 1'b0;
      case (i_op)
         OP_ADD: res_calc[G_N_BIT:0]   = sum;
         OP_SUB: res_calc[G_N_BIT:0]   = diff;
         OP_AND: res_calc[G_N_BIT-1:0] = i_s1 & i_s2;
         OP_OR:  res_calc[G_N_BIT-1:0] = i_s1 | i_s2;
         OP_XOR: res_calc[G_N_BIT-1:0] = i_s1 ^ i_s2;
         OP_SLL: res_calc[G_N_BIT-1:0] = i_s1 << shamt;
         OP_SRL: res_calc[G_N_BIT-1:0] = i_s1 >> shamt;
`ifdef ALU_MUL_EN
         default: res_calc = '0;  // MUL result comes from the iterator
`else
         default: err_calc = 1'b1; // MUL is not built: report it as an error
`endif
      endcase
   end

   // ---------------- register next values ----------------------------------
   always_comb begin
      res_d    = res_q;
      zero_d   = zero_q;
      err_d    = err_q;
      mul_last = 1'b0;
`ifdef ALU_MUL_EN
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      // Add the multiplicand, shifted to the weight of the current
      // multiplier bit.
      acc_next = acc_q + (mplier_q[cnt_q[SW-1:0]] ? (mcand_q << cnt_q) : '0);

      if (accept && is_mul) begin
         mcand_d  = {{G_N_BIT{1'b0}}, i_s1};
         mplier_d = i_s2;
         acc_d    = '0;
         cnt_d    = '0;
         err_d    = 1'b0;
      end else if (accept) begin
         res_d  = res_calc;
         zero_d = (res_calc[G_N_BIT-1:0] == '0);
         err_d  = err_calc;
      end

      if (state_q == S_EXEC) begin
         acc_d = acc_next;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(G_N_BIT - 1)) begin
            mul_last = 1'b1;
            cnt_d    = '0;
            res_d    = acc_next;
            zero_d   = (acc_next[G_N_BIT-1:0] == '0);
         end
      end
`else
      if (accept) begin
         res_d  = res_calc;
         zero_d = (res_calc[G_N_BIT-1:0] == '0);
         err_d  = err_calc;
      end
`endif
   end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- directed bench for alu_seq (G_N_BIT = 8).
// Expected results are hand-computed constants in the vector calls.
// Both the ALU_MUL_EN build and the default build are covered.
// ---------------------------------------------------------------------------
module tb_alu_seq;

   logic        i_clk;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [2:0]  i_op;
   logic [7:0]  i_s1;
   logic [7:0]  i_s2;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_res;
   logic        o_zero;
   logic        o_err;

   int n_cmp;
   int n_bad;

   alu_seq #(.G_N_BIT(8)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_op    (i_op),
      .i_s1    (i_s1),
      .i_s2    (i_s2),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_res   (o_res),
      .o_zero  (o_zero),
      .o_err   (o_err)
   );

   // ---------------- clock ---------------------------------------------
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // ---------------- checker -------------------------------------------
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Issue one command and wait for its result. Then hold off the consumer
   // for 'hold' cycles, throwing junk at the inputs, and finally take the
   // result.
   task automatic run_op(input string tag, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_res, input logic exp_zero,
                         input logic exp_err, input int exp_lat, input int hold);
      int lat;
      check({tag, ".ready_before"}, {31'd0, o_ready}, 32'd1);
      i_op    = op;
      i_s1    = a;
      i_s2    = b;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      i_s1    = 8'($urandom_range(0, 255));
      i_s2    = 8'($urandom_range(0, 255));
      lat = 1;
      while (!o_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ".res"},  {16'd0, o_res}, {16'd0, exp_res});
      check({tag, ".zero"}, {31'd0, o_zero}, {31'd0, exp_zero});
      check({tag, ".err"},  {31'd0, o_err},  {31'd0, exp_err});
      check({tag, ".ready_done"}, {31'd0, o_ready}, 32'd0);
      for (int k = 0; k < hold; k++) begin
         i_valid = 1'b1;
         i_op    = 3'b000;
         i_s1    = 8'($urandom_range(0, 255));
         tick();
         check({tag, ".hold_res"},   {16'd0, o_res}, {16'd0, exp_res});
         check({tag, ".hold_valid"}, {31'd0, o_valid}, 32'd1);
         check({tag, ".hold_ready"}, {31'd0, o_ready}, 32'd0);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check({tag, ".valid_after"}, {31'd0, o_valid}, 32'd0);
      check({tag, ".ready_after"}, {31'd0, o_ready}, 32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".ready"}, {31'd0, o_ready}, 32'd1);
      check({tag, ".valid"}, {31'd0, o_valid}, 32'd0);
      check({tag, ".res"},   {16'd0, o_res}, 32'd0);
      check({tag, ".zero"},  {31'd0, o_zero}, 32'd0);
      check({tag, ".err"},   {31'd0, o_err}, 32'd0);
   endtask

   // ---------------- stimulus ------------------------------------------
   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_op    = 3'b000;
      i_s1    = 8'h00;
      i_s2    = 8'h00;
      tick();
      tick();
      i_rst = 1'b0;
      check_reset_state("reset");

      //      tag       op      s1     s2     res       z     e     lat hold
      run_op("add_ff",  3'b000, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 1, 0);
      run_op("sub_brw", 3'b001, 8'h03, 8'h05, 16'h01FE, 1'b0, 1'b0, 1, 0);
      run_op("sub_eq",  3'b001, 8'h05, 8'h05, 16'h0000, 1'b1, 1'b0, 1, 0);
      run_op("srl",     3'b110, 8'h80, 8'h09, 16'h0040, 1'b0, 1'b0, 1, 0);
      run_op("sll",     3'b101, 8'h81, 8'h01, 16'h0002, 1'b0, 1'b0, 1, 0);
      run_op("sll7",    3'b101, 8'h03, 8'h07, 16'h0080, 1'b0, 1'b0, 1, 0);
      run_op("and",     3'b010, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1, 0);
      run_op("or",      3'b011, 8'hF0, 8'h0F, 16'h00FF, 1'b0, 1'b0, 1, 2);
      run_op("xor",     3'b100, 8'hFF, 8'hFF, 16'h0000, 1'b1, 1'b0, 1, 0);

`ifdef ALU_MUL_EN
      run_op("mul_ff",  3'b111, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 9, 5);
      run_op("mul_3x5", 3'b111, 8'h03, 8'h05, 16'h000F, 1'b0, 1'b0, 9, 0);
      run_op("mul_x00", 3'b111, 8'h00, 8'h7B, 16'h0000, 1'b1, 1'b0, 9, 0);
      run_op("mul_lo0", 3'b111, 8'h10, 8'h10, 16'h0100, 1'b1, 1'b0, 9, 0);

      // Reset in the middle of a multiply.
      i_op    = 3'b111;
      i_s1    = 8'hFF;
      i_s2    = 8'hFF;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      check("mid_mul.busy", {31'd0, o_ready}, 32'd0);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check_reset_state("mul_reset");
      for (int k = 0; k < 10; k++) begin
         tick();
         check("mul_reset.discarded", {31'd0, o_valid}, 32'd0);
      end
`else
      run_op("mul_off", 3'b111, 8'h12, 8'h34, 16'h0000, 1'b1, 1'b1, 1, 3);
      run_op("add_clr", 3'b000, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 1, 0);

      // Reset while the error result is waiting to be taken.
      i_op    = 3'b111;
      i_s1    = 8'h12;
      i_s2    = 8'h34;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      check("err_pending", {31'd0, o_err}, 32'd1);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check_reset_state("err_reset");
`endif

      run_op("add_post", 3'b000, 8'h10, 8'h20, 16'h0030, 1'b0, 1'b0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised ALU: the registered successor to the combinational datapath ALU. It accepts two G_N_BIT operands and a 3-bit opcode over a valid/ready handshake and computes the operation. Logic and add ops take one cycle; the optional multiply takes G_N_BIT cycles via shift-add. A double-width result is returned over a second valid/ready handshake. It sits between the tile IO pins and a future control sequencer.

## Interface
- G_N_BIT, 8, operand width; must be ≥ 2 and a power of two.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  operand/opcode valid.
- o_ready  out  1  block can accept a command.
- i_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL.
- i_s1  in  G_N_BIT  operand A.
- i_s2  in  G_N_BIT  operand B; for shifts only its $clog2(G_N_BIT) LSBs are the shift amount.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_res  out  2*G_N_BIT  result.
- o_zero  out  1  o_res[G_N_BIT-1:0] == 0.
- o_err  out  1  unsupported opcode (MUL when compiled out).

## Operation
- States:
  - IDLE: o_ready=1.
  - EXEC: MUL only.
  - DONE: o_valid=1.
- Command acceptance: on i_valid && o_ready, the block registers i_op, i_s1 and i_s2.
- Transitions:
  - IDLE→DONE for ops 000–110.
  - IDLE→EXEC for MUL.
  - EXEC→DONE after G_N_BIT iterations.
  - DONE→IDLE when i_ready=1.
- Result composition (all unsigned):
  - ADD: o_res = {0…, carry, s1+s2 mod 2^N}.
  - SUB: o_res = {0…, borrow, s1−s2 mod 2^N}; borrow=1 iff s1<s2.
  - AND/OR/XOR/SLL/SRL: N-bit result zero-extended to 2N.
  - MUL: full 2N-bit product.
- Shifts: logical; vacated bits filled with 0; amount = i_s2 mod G_N_BIT.
- MUL iterator:
  - Uses a $clog2(G_N_BIT)+1-bit counter.
  - Each EXEC cycle, adds the shifted multiplicand when the current multiplier bit is 1.
- Output hold: o_res, o_zero and o_err are stable throughout DONE. Inputs are ignored outside IDLE.
- Reset: at any state, including mid-MUL, the next edge forces:
  - state IDLE;
  - o_valid=0, o_ready=1;
  - o_res=0, o_zero=0, o_err=0;
  - counter=0.
  - The in-flight command is discarded.

## Timing
- Single-cycle op accepted at edge t:
  - o_valid=1 after edge t+1;
  - o_ready=0 during the DONE cycle(s).
- MUL accepted at edge t: o_valid=1 after edge t+G_N_BIT+1.
- Result consumed at edge u (o_valid && i_ready): o_valid=0 and o_ready=1 after u.
- No accept in the same cycle as result handoff. Peak throughput is 1 command per 2 cycles for non-MUL ops.
- Backpressure: with i_ready=0, DONE holds indefinitely with no output change.
- No combinational path from any input to o_ready or o_valid.

## Configuration
- ALU_MUL_EN defined:
  - MUL is implemented as above;
  - o_err is always 0.
- ALU_MUL_EN undefined:
  - no multiplier datapath or EXEC counter is synthesised;
  - opcode 111 goes IDLE→DONE in one cycle with o_res=0, o_zero=1, o_err=1.

## Test plan
- ADD, G_N_BIT=8, s1=0xFF, s2=0x01 → o_valid one cycle after accept; o_res=0x0100, o_zero=1, o_err=0.
- SUB, s1=0x03, s2=0x05 → o_res=0x01FE (borrow=1, low=0xFE), o_zero=0.
- SRL, s1=0x80, s2=0x09 → amount 1, o_res=0x0040. SLL, s1=0x81, s2=0x01 → o_res=0x0002.
- MUL (ALU_MUL_EN), s1=0xFF, s2=0xFF → o_valid exactly 9 cycles after accept; o_res=0xFE01. Hold i_ready=0 for 5 cycles → o_res unchanged and o_ready=0 throughout; release → o_ready=1 next cycle.
- Assert i_rst for one cycle 4 cycles into a MUL → next cycle: o_ready=1, o_valid=0, o_res=0. A new ADD 0x10+0x20 → o_res=0x0030.
- Without ALU_MUL_EN, MUL 0x12×0x34 → o_valid after 1 cycle; o_res=0, o_zero=1, o_err=1. The next ADD clears o_err.
